// File: rtl/bus_pkg.sv
// Shared bus widths, idle address and the bus_dma state encoding.
// Imported by every block that sits on the shared byte bus.
package bus_pkg;

  localparam int BUS_DW = 8;
  localparam int BUS_AW = 8;
  localparam logic [BUS_AW-1:0] BUS_IDLE_ADDR = 8'hFF;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_RDA  = 3'd2;
  localparam logic [2:0] S_RDD  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

endpackage

// File: rtl/bus_dma.sv
// Byte-copy DMA engine on a shared tristate bus.
// One byte = read address, turnaround/capture, write; 3 cycles.
module bus_dma
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = BUS_DW,
  parameter logic [DATA_WIDTH-1:0] IDLE_ADDR = BUS_IDLE_ADDR
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] SRC_ADDR,
  input  logic [DATA_WIDTH-1:0] DST_ADDR,
  input  logic [DATA_WIDTH-1:0] LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  BUS_REQ,
  input  logic                  BUS_GNT,
  output logic [DATA_WIDTH-1:0] BUS_ADDR,
  output logic                  BUS_WE,
  inout  wire  [DATA_WIDTH-1:0] BUS_DATA
);

  localparam logic [DATA_WIDTH-1:0] W_ONE =
    {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic [DATA_WIDTH-1:0] r_src;
  logic [DATA_WIDTH-1:0] r_dst;
  logic [DATA_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_byte;
  logic                  r_drv;
  logic                  w_last;
  logic                  w_active;

  assign w_last = (r_cnt == W_ONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_next = (LEN == '0) ? S_FIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (BUS_GNT) begin
          w_next = S_RDA;
        end
      end
      S_RDA: w_next = S_RDD;
      S_RDD: w_next = S_WR;
      // grant is only re-examined between bytes
      S_WR: begin
        if (w_last) begin
          w_next = S_FIN;
        end else if (BUS_GNT) begin
          w_next = S_RDA;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_byte  <= '0;
      r_drv   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drv   <= (w_next == S_WR);
      if (r_state == S_IDLE && START && LEN != '0) begin
        r_src <= SRC_ADDR;
        r_dst <= DST_ADDR;
        r_cnt <= LEN;
      end
      if (r_state == S_RDD) begin
        r_byte <= BUS_DATA;
      end
      if (r_state == S_WR) begin
        r_src <= r_src + W_ONE;
        r_dst <= r_dst + W_ONE;
        r_cnt <= r_cnt - W_ONE;
      end
    end
  end

  assign w_active = (r_state == S_WAIT) || (r_state == S_RDA) ||
                    (r_state == S_RDD)  || (r_state == S_WR);

  assign BUSY    = w_active;
  assign BUS_REQ = w_active;
  assign DONE    = (r_state == S_FIN);
  assign BUS_WE  = (r_state == S_WR);

  // RD_DATA parks the address so the responder lets go before WR
  assign BUS_ADDR = (r_state == S_RDA) ? r_src :
                    (r_state == S_WR)  ? r_dst : IDLE_ADDR;

  assign BUS_DATA = r_drv ? r_byte : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_dma.sv
// Scoreboard bench for bus_dma: RAM responder, copy model, monitors.
// Expected writes are queued at issue time and popped on bus writes.
module tb_bus_dma;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       START;
  logic [7:0] SRC_ADDR;
  logic [7:0] DST_ADDR;
  logic [7:0] LEN;
  logic       BUSY;
  logic       DONE;
  logic       BUS_REQ;
  logic       BUS_GNT;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  wire  [7:0] BUS_DATA;

  logic [7:0] mem   [256];
  logic [7:0] model [256];
  wr_t        exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  logic       r_rsp_en = 1'b0;
  logic [7:0] r_rsp_data = 8'h00;
  logic       r_prev_we = 1'b0;
  logic [7:0] s_addr = 8'hFF;
  logic [7:0] s_data = 8'h00;
  logic       s_we = 1'b0;
  logic       s_req = 1'b0;
  logic       rnd_gnt = 1'b0;

  bus_dma dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
    .SRC_ADDR (SRC_ADDR),
    .DST_ADDR (DST_ADDR),
    .LEN      (LEN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .BUS_REQ  (BUS_REQ),
    .BUS_GNT  (BUS_GNT),
    .BUS_ADDR (BUS_ADDR),
    .BUS_WE   (BUS_WE),
    .BUS_DATA (BUS_DATA)
  );

  always #5 CLK = ~CLK;

  assign BUS_DATA = r_rsp_en ? r_rsp_data : 8'hzz;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Sample the bus mid-cycle; score writes, DONE pulses, contention.
  always @(negedge CLK) begin
    wr_t e;
    s_addr <= BUS_ADDR;
    s_we   <= BUS_WE;
    s_req  <= BUS_REQ;
    s_data <= BUS_DATA;
    if (RESET_N && BUS_WE) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {31'b0, BUS_WE}, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {24'b0, BUS_ADDR}, {24'b0, e.a});
        check("wr_data", {24'b0, BUS_DATA}, {24'b0, e.d});
      end
    end
    check("bus_contention", {31'b0, r_rsp_en & BUS_WE}, 0);
    if (DONE) done_cnt++;
  end

  // RAM responder: data one cycle after address. FF is a real
  // read only when it directly follows a write cycle.
  always @(posedge CLK) begin
    r_prev_we  <= s_we;
    r_rsp_en   <= s_req && !s_we &&
                  (s_addr != 8'hFF || r_prev_we);
    r_rsp_data <= mem[s_addr];
    if (s_we) mem[s_addr] <= s_data;
  end

  always @(negedge CLK) begin
    if (rnd_gnt) BUS_GNT = ($urandom_range(0, 3) != 0);
  end

  task automatic start_copy(input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input int nexp);
    logic [7:0] v;
    for (int i = 0; i < nexp; i++) begin
      v = model[8'(s + i)];
      model[8'(d + i)] = v;
      exp_q.push_back('{a: 8'(d + i), d: v});
    end
    @(negedge CLK);
    SRC_ADDR = s;
    DST_ADDR = d;
    LEN      = l;
    START    = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge CLK);
      k++;
    end
    repeat (3) @(posedge CLK);
    check("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic set_byte(input logic [7:0] a, input logic [7:0] v);
    mem[a]   = v;
    model[a] = v;
  endtask

  initial begin
    int d0;
    int k;
    int t_rd;
    int t_done;
    logic [7:0] s;
    logic [7:0] d;
    logic [7:0] l;
    logic [31:0] exp4;

    RESET_N  = 1'b1;
    START    = 1'b0;
    SRC_ADDR = 8'h00;
    DST_ADDR = 8'h00;
    LEN      = 8'h00;
    BUS_GNT  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      set_byte(8'(i), 8'($urandom));
    end
    #2 RESET_N = 1'b0;
    #1;
    check("rst_busy", {31'b0, BUSY}, 0);
    check("rst_done", {31'b0, DONE}, 0);
    check("rst_req", {31'b0, BUS_REQ}, 0);
    check("rst_we", {31'b0, BUS_WE}, 0);
    check("rst_addr", {24'b0, BUS_ADDR}, 32'hFF);
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // four-byte copy, latency and START-while-busy
    set_byte(8'h10, 8'hA1);
    set_byte(8'h11, 8'hB2);
    set_byte(8'h12, 8'hC3);
    set_byte(8'h13, 8'hD4);
    d0 = done_cnt;
    start_copy(8'h10, 8'h40, 8'd4, 4);
    t_rd = -1;
    t_done = -1;
    for (k = 1; k < 100; k++) begin
      @(negedge CLK);
      if (k == 4) begin
        SRC_ADDR = 8'h00;
        DST_ADDR = 8'h90;
        LEN      = 8'd5;
        START    = 1'b1;
      end
      if (k == 5) START = 1'b0;
      if (t_rd < 0 && BUS_ADDR == 8'h10 && !BUS_WE) t_rd = k;
      if (DONE) begin
        t_done = k;
        break;
      end
    end
    check("len4_latency", t_done - t_rd, 12);
    repeat (20) @(negedge CLK);
    check("len4_done_once", done_cnt - d0, 1);
    exp4 = {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]};
    check("len4_mem", exp4, 32'hA1B2C3D4);
    check("len4_queue", exp_q.size(), 0);

    // zero length: DONE next cycle, bus untouched
    d0 = done_cnt;
    @(negedge CLK);
    SRC_ADDR = 8'h10;
    DST_ADDR = 8'h50;
    LEN      = 8'd0;
    START    = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge CLK);
      START = 1'b0;
      if (j == 1) check("len0_done", {31'b0, DONE}, 1);
      check("len0_req", {31'b0, BUS_REQ}, 0);
      check("len0_we", {31'b0, BUS_WE}, 0);
    end
    check("len0_done_once", done_cnt - d0, 1);

    // pointer wrap on both sides
    set_byte(8'hFE, 8'h5A);
    set_byte(8'hFF, 8'h6B);
    set_byte(8'h00, 8'h7C);
    start_copy(8'hFE, 8'h7E, 8'd3, 3);
    wait_done(100);
    exp4 = {8'h00, mem[8'h7E], mem[8'h7F], mem[8'h80]};
    check("wrap_mem", exp4, 32'h005A6B7C);
    check("wrap_queue", exp_q.size(), 0);

    // grant withdrawn between bytes
    start_copy(8'h20, 8'h60, 8'd3, 3);
    k = 0;
    while (!BUS_WE && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("gnt_reach_wr", {31'b0, BUS_WE}, 1);
    BUS_GNT = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge CLK);
      check("gnt_idle_addr", {24'b0, BUS_ADDR}, 32'hFF);
      check("gnt_idle_we", {31'b0, BUS_WE}, 0);
      check("gnt_busy", {31'b0, BUSY}, 1);
    end
    BUS_GNT = 1'b1;
    wait_done(100);
    for (int j = 0; j < 3; j++) begin
      check("gnt_mem", {24'b0, mem[8'(8'h60 + j)]},
            {24'b0, model[8'(8'h60 + j)]});
    end
    check("gnt_queue", exp_q.size(), 0);

    // reset during RD_DATA of byte 2
    set_byte(8'h70, ~mem[8'h30]);
    set_byte(8'h71, ~mem[8'h31]);
    d0 = done_cnt;
    start_copy(8'h30, 8'h70, 8'd3, 1);
    k = 0;
    while (!(BUS_ADDR == 8'h31 && !BUS_WE) && k < 50) begin
      @(negedge CLK);
      k++;
    end
    check("rst_reach_byte2", {24'b0, BUS_ADDR}, 32'h31);
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    check("mid_rst_busy", {31'b0, BUSY}, 0);
    check("mid_rst_req", {31'b0, BUS_REQ}, 0);
    check("mid_rst_we", {31'b0, BUS_WE}, 0);
    check("mid_rst_addr", {24'b0, BUS_ADDR}, 32'hFF);
    check("mid_rst_done", {31'b0, DONE}, 0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    repeat (6) @(negedge CLK);
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_byte1", {24'b0, mem[8'h70]}, {24'b0, model[8'h70]});
    check("mid_rst_byte2", {24'b0, mem[8'h71]}, {24'b0, model[8'h71]});
    check("mid_rst_queue", exp_q.size(), 0);

    // random copies, overlaps allowed, random grant
    rnd_gnt = 1'b1;
    for (int n = 0; n < 10; n++) begin
      l = 8'($urandom_range(1, 12));
      s = 8'($urandom_range(0, 255 - int'(l)));
      d = 8'($urandom_range(0, 255));
      start_copy(s, d, l, int'(l));
      wait_done(600);
      check("rnd_queue", exp_q.size(), 0);
    end
    rnd_gnt = 1'b0;
    BUS_GNT = 1'b1;
    repeat (4) @(negedge CLK);
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== model[i]) begin
        check("final_mem", {24'b0, mem[i]}, {24'b0, model[i]});
      end
    end
    check("final_mem_sample", {24'b0, mem[8'h43]}, 32'hD4 == 0 ?
          0 : {24'b0, model[8'h43]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_dma.md
BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 Parameter IDLE_ADDR, default 8'hFF, unmapped bus address driven whenever the engine is not addressing a peripheral.
REQ-002 Parameter DATA_WIDTH, default 8, bus data and address width.
REQ-003 CLK  input  1  single system clock; all state changes on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 SRC_ADDR  input  8  first source byte address, captured on accepted START.
REQ-007 DST_ADDR  input  8  first destination byte address, captured on accepted START.
REQ-008 LEN  input  8  byte count, captured on accepted START; 0 means no transfer.
REQ-009 BUSY  output  1  high from the cycle after accepted START until DONE.
REQ-010 DONE  output  1  one-cycle pulse when the copy completes.
REQ-011 BUS_REQ  output  1  bus ownership request to the top-level arbiter.
REQ-012 BUS_GNT  input  1  bus ownership grant; engine bus outputs are muxed onto the shared bus only while high.
REQ-013 BUS_ADDR  output  8  bus address.
REQ-014 BUS_WE  output  1  bus write enable.
REQ-015 BUS_DATA  inout  8  shared tristate data bus; driven by the engine only in WR state, else 8'hZZ.

Function
REQ-016 The engine SHALL implement states IDLE, WAIT_GNT, RD_ADDR, RD_DATA, WR, FIN.
REQ-017 IDLE: START=1 with LEN!=0 SHALL capture SRC/DST/LEN, set BUSY and BUS_REQ, go to WAIT_GNT.
REQ-018 IDLE: START=1 with LEN=0 SHALL go to FIN directly, with no bus cycle and BUS_REQ never asserted.
REQ-019 WAIT_GNT: BUS_GNT=1 SHALL go to RD_ADDR, else remain.
REQ-020 RD_ADDR (1 cycle): BUS_ADDR=src pointer, BUS_WE=0, BUS_DATA released.
REQ-021 RD_DATA (1 cycle): BUS_ADDR=IDLE_ADDR, BUS_WE=0; BUS_DATA SHALL be captured into the byte register at the end of the cycle (responder data valid one cycle after address).
REQ-022 Driving IDLE_ADDR in RD_DATA is the bus turnaround: it guarantees the responder releases BUS_DATA before WR.
REQ-023 WR (1 cycle): BUS_ADDR=dst pointer, BUS_WE=1, BUS_DATA=byte register.
REQ-024 On leaving WR, src and dst pointers SHALL increment modulo 256 (8'hFF wraps to 8'h00) and the remaining count SHALL decrement.
REQ-025 After WR: count now 0 -> FIN; else BUS_GNT=1 -> RD_ADDR; else -> WAIT_GNT (pause between bytes only, never mid-byte).
REQ-026 Each byte SHALL take exactly 3 cycles with continuous grant; LEN=N copy completes in 3N cycles after the first grant.
REQ-027 BUS_GNT falling during RD_ADDR, RD_DATA or WR SHALL NOT abort the byte in progress.
REQ-028 FIN (1 cycle): DONE=1, BUSY=0, BUS_REQ=0; next state IDLE.
REQ-029 Outside RD_ADDR and WR, BUS_ADDR SHALL be IDLE_ADDR and BUS_WE SHALL be 0.
REQ-030 START while not in IDLE SHALL be ignored, no capture.
REQ-031 Overlapping source/destination ranges SHALL be copied strictly in ascending address order, with no hazard detection.

Reset
REQ-032 RESET_N low SHALL immediately force IDLE, BUSY=0, DONE=0, BUS_REQ=0, BUS_WE=0, BUS_ADDR=IDLE_ADDR, BUS_DATA=8'hZZ, pointers, count and byte register cleared.
REQ-033 Reset mid-copy SHALL abandon the transfer; no DONE pulse; bytes already written remain written.

Structure
REQ-034 Shared package bus_pkg SHALL hold the bus widths, IDLE_ADDR and the bus_dma state encoding.
REQ-035 Single module; no sub-module.
REQ-036 BUS_DATA tristate enable SHALL be a registered signal equal to (state==WR).

Verification
REQ-037 RAM model preloaded Mem[0x10..0x13]=A1,B2,C3,D4; GNT tied 1; START with SRC=10, DST=40, LEN=4 -> Mem[40..43]=A1,B2,C3,D4; DONE exactly 12 cycles after first RD_ADDR; one DONE pulse.
REQ-038 LEN=0 START -> DONE on the next cycle; BUS_REQ stays 0; BUS_WE stays 0.
REQ-039 SRC=FE, DST=7E, LEN=3 -> reads FE,FF,00 in order; writes 7E,7F,80 in order; both pointers wrap.
REQ-040 GNT dropped for 5 cycles after byte 1 WR -> engine sits in WAIT_GNT, bus idle (FF, WE=0); resumes on regrant; final memory correct.
REQ-041 RESET_N low during RD_DATA of byte 2 -> all outputs at reset values asynchronously; no DONE; byte 1 written, byte 2 not written.
REQ-042 Bus monitor throughout all tests -> never two drivers on BUS_DATA in one cycle; START while BUSY changes nothing.
